// File: rtl/aes128_cipher_stream.sv
// AES-128 (FIPS-197) streaming encryptor with valid/ready handshakes on both sides.
// RPC rounds are evaluated per clock, and round keys are expanded on the fly alongside the state.
// Optional counter mode is enabled by defining AES128_CTR_EN. It adds ctr_mode, ctr_load,
// ctr_init and a 128-bit counter register.
// Byte 0 of any 128-bit block is bits [127:120]. The state is column-major.
module aes128_cipher_stream #(
  parameter int unsigned RPC = 1
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_key,
  input  logic [127:0] plain_text,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher_text,
  output logic         busy
`ifdef AES128_CTR_EN
  ,
  input  logic         ctr_mode,
  input  logic         ctr_load,
  input  logic [127:0] ctr_init
`endif
);

  if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
    $error("aes128_cipher_stream: RPC must be 1, 2, 5 or 10");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ROUND = 3'b010,
    DONE  = 3'b100
  } state_t;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sub_byte(k[23:16]) ^ rc, sub_byte(k[15:8]), sub_byte(k[7:0]), sub_byte(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [127:0] sr, mc;
    for (int unsigned i = 0; i < 16; i++) sb[i] = sub_byte(s[127-8*i -: 8]);
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
    for (int unsigned c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    return (last ? sr : mc) ^ k;
  endfunction

  state_t               state;
  logic [127:0]         st, rk;
  logic [3:0]           rnd_cnt;
  logic [RPC:0][127:0]  st_chain, rk_chain;
  logic [127:0]         blk_in, result;
  logic                 accept, last_step;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign busy      = (state != IDLE);
  assign last_step = (rnd_cnt == 4'(10 - RPC));

  // RPC rounds chained combinationally; each round's key is expanded from the previous one
  always_comb begin
    logic [3:0] r;
    r = '0;
    st_chain = '0;
    rk_chain = '0;
    st_chain[0] = st;
    rk_chain[0] = rk;
    for (int unsigned i = 0; i < RPC; i++) begin
      r = rnd_cnt + 4'(i) + 4'd1;
      rk_chain[i+1] = key_step(rk_chain[i], rcon(r));
      st_chain[i+1] = aes_round(st_chain[i], rk_chain[i+1], r == 4'd10);
    end
  end

`ifdef AES128_CTR_EN
  logic [127:0] ctr, pad, ctr_base;

  // Cipher input selection: counter (or the counter being loaded this cycle) in CTR mode
  always_comb begin
    ctr_base = ctr_load ? ctr_init : ctr;
    blk_in   = ctr_mode ? ctr_base : plain_text;
    result   = st_chain[RPC] ^ pad;
  end

  // Counter and keystream pad; only the low word counts, wrapping mod 2^32
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      ctr <= '0;
      pad <= '0;
    end else begin
      if (accept && ctr_mode) ctr <= {ctr_base[127:32], ctr_base[31:0] + 32'd1};
      else if (ctr_load)      ctr <= ctr_init;
      if (accept) pad <= ctr_mode ? plain_text : '0;
    end
  end
`else
  assign blk_in = plain_text;
  assign result = st_chain[RPC];
`endif

  // Control FSM and datapath registers. A DONE-state accept overrides the return to IDLE.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state       <= IDLE;
      st          <= '0;
      rk          <= '0;
      rnd_cnt     <= '0;
      cipher_text <= '0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        ROUND: begin
          st      <= st_chain[RPC];
          rk      <= rk_chain[RPC];
          rnd_cnt <= rnd_cnt + 4'(RPC);
          if (last_step) begin
            state       <= DONE;
            cipher_text <= result;
            out_valid   <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
      if (accept) begin
        state   <= ROUND;
        st      <= blk_in ^ cipher_key;
        rk      <= cipher_key;
        rnd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes128_cipher_stream.sv
// Bench for aes128_cipher_stream. Four instances run at RPC = 1, 2, 5 and 10.
// Each instance is checked against an AES-128 reference model built from the
// GF(2^8) definitions: S-box from field inverse plus affine map, FIPS-197 key schedule.
// Define AES128_CTR_EN to also exercise counter mode.
module tb_aes128_cipher_stream;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic              rst_n;
  logic [3:0]        in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0][127:0] cipher_key, plain_text, cipher_text;
`ifdef AES128_CTR_EN
  logic [3:0]        ctr_mode, ctr_load;
  logic [3:0][127:0] ctr_init;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_tab [4] = '{10, 5, 2, 1};
  logic [7:0] sbox_t [256];

  always @(posedge clk_sys) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes128_cipher_stream #(.RPC(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) u_dut (
      .clk_sys     (clk_sys),
      .rst_n       (rst_n),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .cipher_key  (cipher_key[g]),
      .plain_text  (plain_text[g]),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready[g]),
      .cipher_text (cipher_text[g]),
      .busy        (busy[g])
`ifdef AES128_CTR_EN
      ,
      .ctr_mode    (ctr_mode[g]),
      .ctr_load    (ctr_load[g]),
      .ctr_init    (ctr_init[g])
`endif
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, xb, yb;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      xb  = 8'(x);
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (x != 0 && gmul(xb, yb) == 8'h01) inv = yb;
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            s[4*c+r] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers (called at a negedge, return at a negedge) ----------------
  task automatic send(input int k, input logic [127:0] key, input logic [127:0] pt, output int acc);
    acc = -1;
    in_valid[k] = 1'b1;
    cipher_key[k] = key;
    plain_text[k] = pt;
    for (int n = 0; n < 100; n++) begin
      if (in_ready[k]) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk_sys);
    end
    if (acc >= 0) @(negedge clk_sys);
    in_valid[k] = 1'b0;
    cipher_key[k] = rand128();
    plain_text[k] = rand128();
  endtask

  task automatic wait_valid(input int k, output int vcyc);
    vcyc = -1;
    for (int n = 0; n < 100; n++) begin
      if (out_valid[k]) begin
        vcyc = cyc;
        break;
      end
      @(negedge clk_sys);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      checks++; if (in_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, in_ready[k]); end
      checks++; if (out_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid[k]); end
      checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]); end
      checks++; if (cipher_text[k] !== '0) begin errors++; $display("FAIL reset_ct[%0d]: got %h expected 0", k, cipher_text[k]); end
    end
  endtask

  task automatic test_fips_b();
    int acc, vc;
    send(0, KEY_B, PT_B, acc);
    wait_valid(0, vc);
    checks++; if (vc - acc !== 10) begin errors++; $display("FAIL fips_b_latency: got %0d expected 10", vc - acc); end
    checks++; if (cipher_text[0] !== CT_B) begin errors++; $display("FAIL fips_b_ct: got %h expected %h", cipher_text[0], CT_B); end
    @(negedge clk_sys);
  endtask

  task automatic test_fips_c1();
    int acc, vc;
    for (int k = 0; k < 4; k++) begin
      send(k, KEY_C, PT_C, acc);
      wait_valid(k, vc);
      checks++; if (vc - acc !== lat_tab[k]) begin errors++; $display("FAIL c1_latency[%0d]: got %0d expected %0d", k, vc - acc, lat_tab[k]); end
      checks++; if (cipher_text[k] !== CT_C) begin errors++; $display("FAIL c1_ct[%0d]: got %h expected %h", k, cipher_text[k], CT_C); end
      @(negedge clk_sys);
    end
  endtask

  task automatic test_random();
    int acc, vc;
    logic [127:0] key, pt, exp_ct;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 4; b++) begin
        key = rand128();
        pt = rand128();
        exp_ct = aes_ref(key, pt);
        out_ready[k] = 1'b0;
        send(k, key, pt, acc);
        wait_valid(k, vc);
        checks++; if (cipher_text[k] !== exp_ct) begin errors++; $display("FAIL random_ct[%0d]: got %h expected %h", k, cipher_text[k], exp_ct); end
        repeat ($urandom_range(0, 3)) @(negedge clk_sys);
        checks++; if (cipher_text[k] !== exp_ct) begin errors++; $display("FAIL random_hold[%0d]: got %h expected %h", k, cipher_text[k], exp_ct); end
        out_ready[k] = 1'b1;
        @(negedge clk_sys);
        checks++; if (out_valid[k] !== 1'b0) begin errors++; $display("FAIL random_release[%0d]: got %b expected 0", k, out_valid[k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent, got;
    int acc [4];
    logic [127:0] expq [$];
    for (int k = 0; k < 4; k++) begin
      sent = 0;
      got = 0;
      expq.delete();
      out_ready[k] = 1'b1;
      for (int n = 0; n < 200 && got < 4; n++) begin
        if (out_valid[k] && expq.size() > 0) begin
          checks++; if (cipher_text[k] !== expq[0]) begin errors++; $display("FAIL b2b_ct[%0d.%0d]: got %h expected %h", k, got, cipher_text[k], expq[0]); end
          void'(expq.pop_front());
          got++;
        end
        if (in_ready[k] && sent < 4) begin
          cipher_key[k] = (sent % 2 == 1) ? KEY_C : KEY_B;
          plain_text[k] = (sent % 2 == 1) ? PT_C : PT_B;
          in_valid[k] = 1'b1;
          expq.push_back(aes_ref(cipher_key[k], plain_text[k]));
          acc[sent] = cyc + 1;
          sent++;
        end else if (in_ready[k]) begin
          in_valid[k] = 1'b0;
        end
        @(negedge clk_sys);
      end
      in_valid[k] = 1'b0;
      checks++; if (got !== 4) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 4", k, got); end
      for (int i = 1; i < 4; i++) begin
        checks++; if (acc[i] - acc[i-1] !== lat_tab[k] + 1) begin errors++; $display("FAIL b2b_spacing[%0d.%0d]: got %0d expected %0d", k, i, acc[i] - acc[i-1], lat_tab[k] + 1); end
      end
      @(negedge clk_sys);
    end
  endtask

  task automatic test_backpressure(input int k);
    int acc, vc;
    logic [127:0] kx, px, ky, py, ex, ey;
    kx = rand128(); px = rand128(); ky = rand128(); py = rand128();
    ex = aes_ref(kx, px);
    ey = aes_ref(ky, py);
    out_ready[k] = 1'b0;
    send(k, kx, px, acc);
    wait_valid(k, vc);
    in_valid[k] = 1'b1;
    cipher_key[k] = ky;
    plain_text[k] = py;
    for (int n = 0; n < 20; n++) begin
      checks++; if (out_valid[k] !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", k, out_valid[k]); end
      checks++; if (cipher_text[k] !== ex) begin errors++; $display("FAIL bp_ct_stable[%0d]: got %h expected %h", k, cipher_text[k], ex); end
      checks++; if (in_ready[k] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready[k]); end
      @(negedge clk_sys);
    end
    out_ready[k] = 1'b1;
    #1;
    checks++; if (in_ready[k] !== 1'b1) begin errors++; $display("FAIL bp_release_ready[%0d]: got %b expected 1", k, in_ready[k]); end
    acc = cyc + 1;
    @(negedge clk_sys);
    in_valid[k] = 1'b0;
    checks++; if (busy[k] !== 1'b1) begin errors++; $display("FAIL bp_next_busy[%0d]: got %b expected 1", k, busy[k]); end
    checks++; if (out_valid[k] !== 1'b0) begin errors++; $display("FAIL bp_transfer[%0d]: got %b expected 0", k, out_valid[k]); end
    wait_valid(k, vc);
    checks++; if (vc - acc !== lat_tab[k]) begin errors++; $display("FAIL bp_next_latency[%0d]: got %0d expected %0d", k, vc - acc, lat_tab[k]); end
    checks++; if (cipher_text[k] !== ey) begin errors++; $display("FAIL bp_next_ct[%0d]: got %h expected %h", k, cipher_text[k], ey); end
    @(negedge clk_sys);
  endtask

  task automatic test_reset_mid();
    int acc, vc;
    out_ready[0] = 1'b1;
    send(0, rand128(), rand128(), acc);
    repeat (4) @(negedge clk_sys);
    rst_n = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready[0]); end
    repeat (12) @(negedge clk_sys);
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL rstmid_dropped: got %b expected 0", out_valid[0]); end
    send(0, KEY_B, PT_B, acc);
    wait_valid(0, vc);
    checks++; if (cipher_text[0] !== CT_B) begin errors++; $display("FAIL rstmid_next_ct: got %h expected %h", cipher_text[0], CT_B); end
    @(negedge clk_sys);
  endtask

`ifdef AES128_CTR_EN
  task automatic test_ctr();
    int acc, vc;
    logic [127:0] init, pad, expv;
    init = {96'h0, 32'hffffffff};
    out_ready[0] = 1'b1;
    ctr_mode[0] = 1'b1;
    ctr_load[0] = 1'b1;
    ctr_init[0] = init;
    send(0, KEY_C, '0, acc);
    ctr_load[0] = 1'b0;
    ctr_init[0] = rand128();
    wait_valid(0, vc);
    expv = aes_ref(KEY_C, init);
    checks++; if (cipher_text[0] !== expv) begin errors++; $display("FAIL ctr_load_ct: got %h expected %h", cipher_text[0], expv); end
    @(negedge clk_sys);
    pad = rand128();
    send(0, KEY_C, pad, acc);
    wait_valid(0, vc);
    expv = aes_ref(KEY_C, '0) ^ pad;
    checks++; if (cipher_text[0] !== expv) begin errors++; $display("FAIL ctr_wrap_ct: got %h expected %h", cipher_text[0], expv); end
    @(negedge clk_sys);
    ctr_mode[0] = 1'b0;
    send(0, KEY_B, PT_B, acc);
    wait_valid(0, vc);
    checks++; if (cipher_text[0] !== CT_B) begin errors++; $display("FAIL ctr_ecb_ct: got %h expected %h", cipher_text[0], CT_B); end
    @(negedge clk_sys);
    ctr_mode[0] = 1'b1;
    pad = rand128();
    send(0, KEY_B, pad, acc);
    ctr_mode[0] = 1'b0;
    wait_valid(0, vc);
    expv = aes_ref(KEY_B, 128'h1) ^ pad;
    checks++; if (cipher_text[0] !== expv) begin errors++; $display("FAIL ctr_incr_ct: got %h expected %h", cipher_text[0], expv); end
    @(negedge clk_sys);
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '1;
    cipher_key = '0;
    plain_text = '0;
`ifdef AES128_CTR_EN
    ctr_mode = '0;
    ctr_load = '0;
    ctr_init = '0;
`endif
    build_sbox();
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_random();
    test_back_to_back();
    test_backpressure(0);
    test_backpressure(3);
    test_reset_mid();
`ifdef AES128_CTR_EN
    test_ctr();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
